// File: rtl/s1494_slice_tester_pkg.sv
// Shared types and constants for the s1494 slice stimulus/response engine:
// FSM states, LFSR/MISR polynomials and vector bit positions.
package s1494_tb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CAPTURE,
      ST_DONE
   } state_t;

   localparam logic [13:0] LFSR_TAPS  = 14'h2015;
   localparam logic [15:0] CRC16_POLY = 16'h1021;

   localparam int unsigned VEC_CLR = 13;
   localparam int unsigned V0  = 0;
   localparam int unsigned V1  = 1;
   localparam int unsigned V2  = 2;
   localparam int unsigned V3  = 3;
   localparam int unsigned V4  = 4;
   localparam int unsigned V5  = 5;
   localparam int unsigned V6  = 6;
   localparam int unsigned V7  = 7;
   localparam int unsigned V8  = 8;
   localparam int unsigned V9  = 9;
   localparam int unsigned V10 = 10;
   localparam int unsigned V11 = 11;
   localparam int unsigned V12 = 12;

   function automatic logic [13:0] lfsr_step(input logic [13:0] q);
      return {q[12:0], ^(q & LFSR_TAPS)};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic resp);
      return {sig[14:0], 1'b0} ^ ((sig[15] ^ resp) ? CRC16_POLY : 16'h0000);
   endfunction

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   function automatic logic [13:0] seed_fix(input logic [13:0] seed);
      return (seed == 14'h0000) ? 14'h0001 : seed;
   endfunction

endpackage

// File: rtl/s1494_slice_tester_lfsr_misr_core.sv
// Stimulus LFSR and response MISR registers with load/step/capture enables.
module lfsr_misr_core
   import s1494_tb_pkg::*;
#(
   parameter logic [13:0] SEED      = 14'h0001,
   parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        step,
   input  logic        capture,
   input  logic        resp,
   output logic [13:0] lfsr,
   output logic [13:0] lfsr_next,
   output logic [15:0] signature
);

   always_comb begin
      lfsr_next = lfsr_step(lfsr);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lfsr      <= SEED;
         signature <= MISR_SEED;
      end else begin
         if (load) begin
            lfsr <= SEED;
         end else if (step) begin
            lfsr <= lfsr_next;
         end
         if (load) begin
            signature <= MISR_SEED;
         end else if (capture) begin
            signature <= misr_step(signature, resp);
         end
      end
   end

endmodule

// File: rtl/s1494_slice_tester.sv
// Drives LFSR vectors into an s1494 slice, waits SETTLE cycles, and folds
// the slice response into a CRC-16 MISR signature over N_PAT patterns.
module s1494_slice_tester
   import s1494_tb_pkg::*;
#(
   parameter int unsigned N_PAT     = 1024,
   parameter int unsigned SETTLE    = 0,
   parameter logic [13:0] LFSR_SEED = 14'h0001,
   parameter logic [15:0] MISR_SEED = 16'hFFFF
) (
   input  logic        CK,
   input  logic        CLR,
   input  logic        start,
   output logic [13:0] vec,
   input  logic        resp,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [15:0] pat_count
);

   localparam logic [13:0] SEED_EFF    = seed_fix(LFSR_SEED);
   localparam logic [15:0] N_LAST      = 16'(N_PAT);
   localparam logic [3:0]  SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   state_t      state;
   state_t      state_next;
   logic [3:0]  settle_cnt;
   logic [13:0] lfsr;
   logic [13:0] lfsr_next;
   logic        load;
   logic        step;
   logic        capture;
   logic        last;

   always_comb begin
      last = (pat_count + 16'd1) == N_LAST;
   end

   always_ff @(posedge CK) begin
      if (!CLR) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      step       = 1'b0;
      capture    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = ST_APPLY;
            end
         end
         ST_APPLY: begin
            busy = 1'b1;
            if (SETTLE != 0) begin
               state_next = ST_SETTLE;
            end else begin
               state_next = ST_CAPTURE;
            end
         end
         ST_SETTLE: begin
            busy = 1'b1;
            if (settle_cnt == 4'd0) begin
               state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            busy    = 1'b1;
            capture = 1'b1;
            if (last) begin
               state_next = ST_DONE;
            end else begin
               step       = 1'b1;
               state_next = ST_APPLY;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (!start) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // vec is loaded on the edge entering APPLY, so it mirrors the value the
   // LFSR takes on that same edge (seed on load, advanced value on step).
   always_ff @(posedge CK) begin
      if (!CLR) begin
         vec        <= '0;
         pat_count  <= '0;
         settle_cnt <= '0;
      end else begin
         if (load) begin
            vec <= SEED_EFF;
         end else if (step) begin
            vec <= lfsr_next;
         end
         if (load) begin
            pat_count <= '0;
         end else if (capture) begin
            pat_count <= pat_count + 16'd1;
         end
         if (state == ST_APPLY) begin
            settle_cnt <= SETTLE_LAST;
         end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
         end
      end
   end

   lfsr_misr_core #(
      .SEED      (SEED_EFF),
      .MISR_SEED (MISR_SEED)
   ) u_core (
      .clk       (CK),
      .rst_n     (CLR),
      .load      (load),
      .step      (step),
      .capture   (capture),
      .resp      (resp),
      .lfsr      (lfsr),
      .lfsr_next (lfsr_next),
      .signature (signature)
   );

endmodule

// File: tb/tb_s1494_slice_tester.sv
// Bench for s1494_slice_tester: four parameterisations checked every cycle
// against a pattern-level model, plus hand-computed literal expectations.
module tb_s1494_slice_tester;

   localparam int NP [4] = '{4, 2, 16383, 4};
   localparam int SP [4] = '{0, 3, 0, 2};

   logic        CK = 1'b0;
   logic        CLR;
   logic        start_v [4];
   logic        resp_b;
   logic [13:0] vec_w  [4];
   logic        busy_w [4];
   logic        done_w [4];
   logic [15:0] sig_w  [4];
   logic [15:0] pat_w  [4];

   int n_vec = 0;
   int n_bad = 0;
   bit armed = 1'b0;

   always #5 CK = ~CK;

   s1494_slice_tester #(.N_PAT(4), .SETTLE(0)) dut_a (
      .CK(CK), .CLR(CLR), .start(start_v[0]), .vec(vec_w[0]), .resp(1'b0),
      .busy(busy_w[0]), .done(done_w[0]), .signature(sig_w[0]), .pat_count(pat_w[0]));

   s1494_slice_tester #(.N_PAT(2), .SETTLE(3)) dut_b (
      .CK(CK), .CLR(CLR), .start(start_v[1]), .vec(vec_w[1]), .resp(resp_b),
      .busy(busy_w[1]), .done(done_w[1]), .signature(sig_w[1]), .pat_count(pat_w[1]));

   s1494_slice_tester #(.N_PAT(16383), .SETTLE(0), .LFSR_SEED(14'h0000)) dut_c (
      .CK(CK), .CLR(CLR), .start(start_v[2]), .vec(vec_w[2]), .resp(vec_w[2][0]),
      .busy(busy_w[2]), .done(done_w[2]), .signature(sig_w[2]), .pat_count(pat_w[2]));

   s1494_slice_tester #(.N_PAT(4), .SETTLE(2)) dut_d (
      .CK(CK), .CLR(CLR), .start(start_v[3]), .vec(vec_w[3]), .resp(^vec_w[3]),
      .busy(busy_w[3]), .done(done_w[3]), .signature(sig_w[3]), .pat_count(pat_w[3]));

   function automatic logic [13:0] lstep(input logic [13:0] q);
      return {q[12:0], q[13] ^ q[4] ^ q[2] ^ q[0]};
   endfunction

   function automatic logic [15:0] crc(input logic [15:0] s, input logic r);
      logic [15:0] n;
      n = {s[14:0], 1'b0};
      if (s[15] ^ r) n = n ^ 16'h1021;
      return n;
   endfunction

   // Whole-run signature from seed 1; mode 0: resp=0, 1: resp=vec[0], 2: resp=parity(vec)
   function automatic logic [15:0] ref_sig(input int n, input int mode);
      logic [13:0] q;
      logic [15:0] s;
      logic        r;
      q = 14'h0001;
      s = 16'hFFFF;
      for (int k = 0; k < n; k++) begin
         r = (mode == 1) ? q[0] : (mode == 2) ? ^q : 1'b0;
         s = crc(s, r);
         q = lstep(q);
      end
      return s;
   endfunction

   typedef struct {
      bit          run;
      bit          dn;
      int          t;
      logic [13:0] q;
      logic [13:0] v;
      logic [15:0] s;
      logic [15:0] n;
   } mdl_t;

   mdl_t m [4];

   // One clock edge of the model: t counts edges since the start edge, and
   // every (SETTLE+2)-th edge of a run is a capture.
   function automatic mdl_t adv(input mdl_t x, input int i, input bit clr, input bit st, input bit rb);
      bit r;
      if (!clr) begin
         x.run = 0; x.dn = 0; x.t = 0; x.q = 14'h0001;
         x.v = '0; x.s = 16'hFFFF; x.n = '0;
      end else if (x.run) begin
         x.t++;
         if (x.t % (SP[i] + 2) == 0) begin
            case (i)
               0:       r = 1'b0;
               1:       r = rb;
               2:       r = x.v[0];
               default: r = ^x.v;
            endcase
            x.s = crc(x.s, r);
            x.n = x.n + 16'd1;
            if (x.n == 16'(NP[i])) begin
               x.run = 0;
               x.dn  = 1;
            end else begin
               x.q = lstep(x.q);
               x.v = x.q;
            end
         end
      end else if (x.dn) begin
         if (!st) x.dn = 0;
      end else if (st) begin
         x.run = 1; x.t = 0; x.q = 14'h0001; x.v = 14'h0001;
         x.s = 16'hFFFF; x.n = '0;
      end
      return x;
   endfunction

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge CK);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         m[i] = '{run: 0, dn: 0, t: 0, q: 14'h0001, v: '0, s: 16'hFFFF, n: '0};
      end
      @(posedge CK);
      armed = 1'b1;
   end

   always @(negedge CK) begin
      if (armed) begin
         for (int i = 0; i < 4; i++) begin
            chk("busy", i, 32'(busy_w[i]), 32'(m[i].run));
            chk("done", i, 32'(done_w[i]), 32'(m[i].dn));
            chk("vec", i, 32'(vec_w[i]), 32'(m[i].v));
            chk("signature", i, 32'(sig_w[i]), 32'(m[i].s));
            chk("pat_count", i, 32'(pat_w[i]), 32'(m[i].n));
         end
      end
      for (int i = 0; i < 4; i++) begin
         m[i] = adv(m[i], i, CLR, start_v[i], resp_b);
      end
   end

   initial begin
      logic [31:0] rpat;
      int k;
      rpat   = 32'hB4E1_9C37;
      k      = 0;
      resp_b = 1'b0;
      forever begin
         @(posedge CK);
         #1;
         resp_b = rpat[k % 32];
         k++;
      end
   end

   initial begin
      logic [13:0] av [4];
      bit seen [16384];
      int c;
      int rep;
      int napp;
      av  = '{14'h0001, 14'h0003, 14'h0007, 14'h000E};
      CLR = 1'b0;
      for (int i = 0; i < 4; i++) start_v[i] = 1'b0;
      repeat (3) cyc();
      chk("rst_vec", 0, 32'(vec_w[0]), 32'h0);
      chk("rst_sig", 0, 32'(sig_w[0]), 32'hFFFF);
      CLR = 1'b1;
      cyc();

      // Vector sequence, start toggling while busy, hold/drop in DONE
      start_v[0] = 1'b1;
      for (int cc = 1; cc <= 9; cc++) begin
         cyc();
         if (cc % 2 == 1 && cc < 9) chk("a_vec", 0, 32'(vec_w[0]), 32'(av[cc / 2]));
         if (cc == 8) chk("a_done_early", 0, 32'(done_w[0]), 32'h0);
         if (cc == 9) begin
            chk("a_done_at_9", 0, 32'(done_w[0]), 32'h1);
            chk("a_sig", 0, 32'(sig_w[0]), 32'h0E1F);
            chk("a_pat", 0, 32'(pat_w[0]), 32'd4);
         end
         case (cc)
            1: start_v[0] = 1'b0;
            3: start_v[0] = 1'b1;
            5: start_v[0] = 1'b0;
            7: start_v[0] = 1'b1;
            default: ;
         endcase
      end
      repeat (3) cyc();
      chk("a_hold_done", 0, 32'(done_w[0]), 32'h1);
      start_v[0] = 1'b0;
      cyc();
      chk("a_drop_done", 0, 32'(done_w[0]), 32'h0);
      chk("a_drop_busy", 0, 32'(busy_w[0]), 32'h0);
      start_v[0] = 1'b1;
      repeat (9) cyc();
      chk("a_rerun_done", 0, 32'(done_w[0]), 32'h1);
      chk("a_rerun_sig", 0, 32'(sig_w[0]), 32'h0E1F);
      start_v[0] = 1'b0;
      cyc();

      // Settle window
      start_v[1] = 1'b1;
      for (int cc = 1; cc <= 11; cc++) begin
         cyc();
         if (cc == 1) start_v[1] = 1'b0;
         if (cc == 5) chk("b_vec_p0_hold", 1, 32'(vec_w[1]), 32'h0001);
         if (cc == 6) chk("b_vec_p1", 1, 32'(vec_w[1]), 32'h0003);
         if (cc == 10) chk("b_done_early", 1, 32'(done_w[1]), 32'h0);
         if (cc == 11) begin
            chk("b_done_at_11", 1, 32'(done_w[1]), 32'h1);
            chk("b_pat", 1, 32'(pat_w[1]), 32'd2);
         end
      end
      cyc();

      // Clean run, then reset during SETTLE of pattern 3 with start held
      start_v[3] = 1'b1;
      for (int cc = 1; cc <= 17; cc++) begin
         cyc();
         if (cc == 1) start_v[3] = 1'b0;
      end
      chk("d_done", 3, 32'(done_w[3]), 32'h1);
      chk("d_sig_clean", 3, 32'(sig_w[3]), 32'(ref_sig(4, 2)));
      cyc();
      start_v[3] = 1'b1;
      repeat (10) cyc();
      chk("d_pat_mid", 3, 32'(pat_w[3]), 32'd2);
      CLR = 1'b0;
      cyc();
      chk("d_rst_busy", 3, 32'(busy_w[3]), 32'h0);
      chk("d_rst_sig", 3, 32'(sig_w[3]), 32'hFFFF);
      chk("d_rst_pat", 3, 32'(pat_w[3]), 32'h0);
      chk("d_rst_vec", 3, 32'(vec_w[3]), 32'h0);
      CLR = 1'b1;
      cyc();
      chk("d_restart_busy", 3, 32'(busy_w[3]), 32'h1);
      chk("d_restart_vec", 3, 32'(vec_w[3]), 32'h0001);
      start_v[3] = 1'b0;
      repeat (16) cyc();
      chk("d_done_again", 3, 32'(done_w[3]), 32'h1);
      chk("d_sig_again", 3, 32'(sig_w[3]), 32'(ref_sig(4, 2)));
      cyc();

      // Zero seed, full LFSR period with resp = vec[0]
      for (int i = 0; i < 16384; i++) seen[i] = 1'b0;
      rep  = 0;
      napp = 0;
      start_v[2] = 1'b1;
      cyc();
      start_v[2] = 1'b0;
      c = 1;
      chk("c_first_vec", 2, 32'(vec_w[2]), 32'h0001);
      while (!done_w[2] && c < 40000) begin
         if (busy_w[2] && (c % 2 == 1)) begin
            if (seen[vec_w[2]]) rep++;
            seen[vec_w[2]] = 1'b1;
            napp++;
         end
         cyc();
         c++;
      end
      chk("c_done_reached", 2, 32'(done_w[2]), 32'h1);
      chk("c_done_cycle", 2, 32'(c), 32'(1 + 16383 * 2));
      chk("c_repeats", 2, 32'(rep), 32'h0);
      chk("c_applies", 2, 32'(napp), 32'd16383);
      chk("c_pat", 2, 32'(pat_w[2]), 32'd16383);
      chk("c_sig", 2, 32'(sig_w[2]), 32'(ref_sig(16383, 1)));
      repeat (2) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
